// File: rtl/mdu_pkg.sv
// Shared MDU constants: operation codes on ctrl and the HI/LO read-select encoding.
package mdu_pkg;

   localparam logic [2:0] MDU_mult  = 3'd0;
   localparam logic [2:0] MDU_multu = 3'd1;
   localparam logic [2:0] MDU_div   = 3'd2;
   localparam logic [2:0] MDU_divu  = 3'd3;
   localparam logic [2:0] MDU_mthi  = 3'd4;
   localparam logic [2:0] MDU_mtlo  = 3'd5;

   localparam logic MDU_lo = 1'b0;
   localparam logic MDU_hi = 1'b1;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. Results are computed
// at issue, staged, and committed after a fixed latency.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  ctrl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] RD
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi, lo, stage_hi, stage_lo;
   logic             stage_wr;

   logic [63:0] a_sx, b_sx, prod_s, prod_u;
   logic [31:0] a_mag, b_mag, bs_safe, bu_safe, q_mag, r_mag, sq, sr, uq, ur;
   logic [31:0] nxt_hi, nxt_lo;
   logic        nxt_wr, long_op, div_op;

   always_comb begin
      a_sx    = {{32{A[31]}}, A};
      b_sx    = {{32{B[31]}}, B};
      prod_s  = a_sx * b_sx;
      prod_u  = {32'd0, A} * {32'd0, B};
      a_mag   = A[31] ? (~A + 32'd1) : A;
      b_mag   = B[31] ? (~B + 32'd1) : B;
      // Divisors are forced non-zero so the dividers never see 0; the result is discarded anyway.
      bs_safe = (B == '0) ? 32'd1 : b_mag;
      bu_safe = (B == '0) ? 32'd1 : B;
      q_mag   = a_mag / bs_safe;
      r_mag   = a_mag % bs_safe;
      sq      = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
      sr      = A[31] ? (~r_mag + 32'd1) : r_mag;
      uq      = A / bu_safe;
      ur      = A % bu_safe;
      nxt_hi  = '0;
      nxt_lo  = '0;
      nxt_wr  = 1'b0;
      long_op = 1'b0;
      div_op  = 1'b0;
      case (ctrl)
         MDU_mult:  begin nxt_hi = prod_s[63:32]; nxt_lo = prod_s[31:0]; nxt_wr = 1'b1; long_op = 1'b1; end
         MDU_multu: begin nxt_hi = prod_u[63:32]; nxt_lo = prod_u[31:0]; nxt_wr = 1'b1; long_op = 1'b1; end
         MDU_div:   begin nxt_hi = sr; nxt_lo = sq; nxt_wr = (B != '0); long_op = 1'b1; div_op = 1'b1; end
         MDU_divu:  begin nxt_hi = ur; nxt_lo = uq; nxt_wr = (B != '0); long_op = 1'b1; div_op = 1'b1; end
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         stage_hi <= '0;
         stage_lo <= '0;
         stage_wr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (long_op) begin
                     stage_hi <= nxt_hi;
                     stage_lo <= nxt_lo;
                     stage_wr <= nxt_wr;
                     cnt      <= div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                     state    <= RUN;
                  end else if (ctrl == MDU_mthi) begin
                     hi <= A;
                  end else if (ctrl == MDU_mtlo) begin
                     lo <= A;
                  end
               end
            end
            RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  if (stage_wr) begin
                     hi <= stage_hi;
                     lo <= stage_lo;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign RD   = (rd_sel == MDU_hi) ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the driver queues expected busy lengths and read values,
// a negedge monitor pops and compares them.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  ctrl = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        rd_sel = 1'b0;
   logic        busy;
   logic [31:0] RD;

   logic        rd_req = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int          busy_q[$];
   logic [31:0] rd_q[$];
   string       rd_name_q[$];
   int          bcnt = 0;
   logic        pbusy = 1'b0;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .ctrl(ctrl), .A(A), .B(B),
      .rd_sel(rd_sel), .busy(busy), .RD(RD)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: measures each busy pulse and checks read requests.
   always @(negedge clk) begin
      if (!reset) begin
         bcnt  = 0;
         pbusy = 1'b0;
      end else begin
         if (busy === 1'b1) bcnt++;
         else if (pbusy) begin
            if (busy_q.size() == 0) chk("busy_unexpected", 32'(bcnt), 32'd0);
            else chk("busy_len", 32'(bcnt), 32'(busy_q.pop_front()));
            bcnt = 0;
         end
         pbusy = (busy === 1'b1);
         if (rd_req) begin
            if (rd_q.size() == 0) chk("rd_unexpected", RD, 32'hDEADBEEF);
            else chk(rd_name_q.pop_front(), RD, rd_q.pop_front());
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; ctrl = op; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic long_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
      busy_q.push_back(n);
      issue(op, a, b);
   endtask

   task automatic rd(input string name, input logic sel, input logic [31:0] exp);
      @(posedge clk); #1;
      rd_sel = sel; rd_req = 1'b1;
      rd_q.push_back(exp);
      rd_name_q.push_back(name);
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk({name, "_timeout"}, 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rd", RD, 32'd0);
      #13 reset = 1'b1;
      rd("post_reset_hi", MDU_hi, 32'd0);
      rd("post_reset_lo", MDU_lo, 32'd0);

      // MTHI then MTLO on back-to-back cycles
      @(posedge clk); #1;
      start = 1'b1; ctrl = MDU_mthi; A = 32'h12345678;
      @(posedge clk); #1;
      chk("mthi_busy", 32'(busy), 32'd0);
      ctrl = MDU_mtlo; A = 32'h9ABCDEF0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mtlo_busy", 32'(busy), 32'd0);
      rd("mthi_rd", MDU_hi, 32'h12345678);
      rd("mtlo_rd", MDU_lo, 32'h9ABCDEF0);

      // MULT -2 * 3, old values visible while busy
      long_op(MDU_mult, 32'hFFFFFFFE, 32'd3, 5);
      rd("mult_old_hi", MDU_hi, 32'h12345678);
      wait_idle("mult");
      rd("mult_hi", MDU_hi, 32'hFFFFFFFF);
      rd("mult_lo", MDU_lo, 32'hFFFFFFFA);

      long_op(MDU_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
      wait_idle("multu");
      rd("multu_hi", MDU_hi, 32'hFFFFFFFE);
      rd("multu_lo", MDU_lo, 32'h00000001);

      long_op(MDU_div, 32'hFFFFFFF9, 32'd2, 10);
      rd("div_old_lo", MDU_lo, 32'h00000001);
      wait_idle("div");
      rd("div_lo", MDU_lo, 32'hFFFFFFFD);
      rd("div_hi", MDU_hi, 32'hFFFFFFFF);

      long_op(MDU_div, 32'd7, 32'hFFFFFFFE, 10);
      wait_idle("div_negb");
      rd("div_negb_lo", MDU_lo, 32'hFFFFFFFD);
      rd("div_negb_hi", MDU_hi, 32'd1);

      long_op(MDU_divu, 32'd100, 32'd7, 10);
      wait_idle("divu");
      rd("divu_lo", MDU_lo, 32'd14);
      rd("divu_hi", MDU_hi, 32'd2);

      // Divide by zero leaves HI/LO untouched
      issue(MDU_mthi, 32'h11, 32'd0);
      issue(MDU_mtlo, 32'h22, 32'd0);
      long_op(MDU_divu, 32'd7, 32'd0, 10);
      wait_idle("divz");
      rd("divz_hi", MDU_hi, 32'h11);
      rd("divz_lo", MDU_lo, 32'h22);

      long_op(MDU_div, 32'h80000000, 32'hFFFFFFFF, 10);
      wait_idle("div_ovf");
      rd("div_ovf_lo", MDU_lo, 32'h80000000);
      rd("div_ovf_hi", MDU_hi, 32'd0);

      // Start pulse during busy must be ignored
      long_op(MDU_mult, 32'h00010000, 32'h00010000, 5);
      @(posedge clk); #1;
      start = 1'b1; ctrl = MDU_divu; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("mult_ign");
      rd("mult_ign_hi", MDU_hi, 32'd1);
      rd("mult_ign_lo", MDU_lo, 32'd0);

      // Async reset in the middle of a MULT
      issue(MDU_mult, 32'd5, 32'd7);
      repeat (2) begin @(posedge clk); #1; end
      chk("abort_busy_before", 32'(busy), 32'd1);
      #3 reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      rd_sel = MDU_hi; #1;
      chk("abort_rd_hi", RD, 32'd0);
      rd_sel = MDU_lo; #1;
      chk("abort_rd_lo", RD, 32'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      rd("abort_hi", MDU_hi, 32'd0);
      rd("abort_lo", MDU_lo, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_commit", RD, 32'd0);
      chk("busy_q_drained", 32'(busy_q.size()), 32'd0);
      chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU, directly upstream of the data-memory stage.
- Executes MULT/MULTU/DIV/DIVU with fixed latencies and holds architectural HI/LO.
- Serves MTHI/MTLO writes and MFHI/MFLO reads; its result travels through EX/MEM into the MEM stage.
- Exposes busy so the hazard unit stalls dependent HI/LO instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1)
- CNT_W, 4, counter width; 2^CNT_W must exceed max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 resets immediately, independent of clk
- start  in  1  op valid this cycle (EX instruction is an MDU op, not stalled/flushed)
- ctrl  in  3  operation code, MDU_* constants
- A  in  32  rs operand
- B  in  32  rt operand
- rd_sel  in  1  0 = LO, 1 = HI
- busy  out  1  computation in flight
- RD  out  32  selected HI/LO value (MFHI/MFLO)

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, busy=0, counter=0, staged results=0; RD=0 while asserted.
- States: IDLE, RUN.
- IDLE, start=1, ctrl MULT/MULTU/DIV/DIVU: results computed from A/B, stored in staging registers at that edge. Counter loaded with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- IDLE, start=1, ctrl MTHI/MTLO: HI (resp. LO) <= A at that edge. Stay IDLE; busy stays 0.
- IDLE, start=0 or undefined ctrl: no state change.
- RUN: busy=1 for exactly N cycles after the start edge. Counter decrements each edge. At the edge where it reaches 0, HI/LO <= staged values and the unit returns to IDLE; busy=0 from the next cycle.
- Timing example: start sampled at edge T, N=5. busy high during cycles T+1..T+5. HI/LO new from T+5 edge onward. busy low from cycle T+6.
- start while busy=1: ignored entirely; no restart, no HI/LO write. The hazard unit guarantees this never happens; the bench checks it is harmless.
- RD = rd_sel ? HI : LO, combinational. During RUN it returns the old (committed) values; staged results are never visible.
- Arithmetic rules:
  - MULT: signed 32x32 to 64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: unsigned 32x32 to 64; same split.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (B==0): full DIV_CYCLES latency still taken; HI/LO left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
- Reset mid-RUN: operation aborted; all state cleared per the reset rule.
- Hazard contract: the stall unit stalls any MDU instruction in ID when (start && ctrl is mult/div) || busy.

Decomposition:
- Shared macros file holds the opcode constants: MDU_mult=0, MDU_multu=1, MDU_div=2, MDU_divu=3, MDU_mthi=4, MDU_mtlo=5.
- The shared macros file also holds a rd_sel encoding (MDU_lo=0, MDU_hi=1).
- The state encoding is local to the block.
- No sub-module: the arithmetic is one combinational block feeding the staging registers, with the FSM/counter in the same module.

Test Plan:
- Reset pulled low mid-simulation, asynchronously between edges -> busy=0 and RD=0 immediately. After release, MFHI/MFLO read 0.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles. Old HI/LO readable during busy. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 with HI=0x11, LO=0x22 -> 10 busy cycles, then HI=0x11, LO=0x22 unchanged.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles -> busy stays 0. RD with rd_sel=1/0 returns those values on the following cycles.
- Start MULT, pulse start=1 DIVU on cycle 3 of busy, then reset low on cycle 4 of another MULT -> the first MULT completes unaffected with its own result. The second MULT is aborted: HI=LO=0, busy=0.
